// File: rtl/iiitb_vm_slot_arb.sv
// rtl/iiitb_vm_slot_arb.sv - round-robin arbiter sharing one vending core among coin-slot requesters

module iiitb_vm_slot_arb #(
  parameter int N_REQ    = 4,
  parameter int TIMEOUT  = 16,
  parameter int RESP_WIN = 4,
  parameter int RST_CYC  = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [2*N_REQ-1:0] i_coin,
  output logic [N_REQ-1:0]   o_coin_ack,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_done,
  output logic [1:0]         o_done_change,
  output logic [N_REQ-1:0]   o_abort,
  output logic               o_busy,
  output logic [1:0]         o_vm_in,
  output logic               o_vm_rst,
  input  logic               i_vm_out,
  input  logic [1:0]         i_vm_change
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WW = $clog2(RESP_WIN + 1);
  localparam int CW = $clog2(RST_CYC + 1);

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_LOW     = 2'b01;
  localparam logic [1:0] COIN_HIGH    = 2'b10;
  localparam logic [1:0] COIN_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  // Registered state and outputs
  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_gidx;
  logic [N_REQ-1:0] r_grant;
  logic [TW-1:0]    r_timer;
  logic [WW-1:0]    r_win;
  logic [CW-1:0]    r_rcnt;
  logic [N_REQ-1:0] r_coin_ack;
  logic [N_REQ-1:0] r_done;
  logic [1:0]       r_done_change;
  logic [N_REQ-1:0] r_abort;
  logic             r_busy;
  logic [1:0]       r_vm_in;
  logic             r_vm_rst;

  // Next-state values
  state_t           w_state_n;
  logic [PW-1:0]    w_ptr_n;
  logic [PW-1:0]    w_gidx_n;
  logic [N_REQ-1:0] w_grant_n;
  logic [TW-1:0]    w_timer_n;
  logic [WW-1:0]    w_win_n;
  logic [CW-1:0]    w_rcnt_n;
  logic [N_REQ-1:0] w_coin_ack_n;
  logic [N_REQ-1:0] w_done_n;
  logic [1:0]       w_done_change_n;
  logic [N_REQ-1:0] w_abort_n;
  logic             w_busy_n;
  logic [1:0]       w_vm_in_n;
  logic             w_vm_rst_n;

  // Helpers
  logic [PW:0]      w_rr_sum;
  logic [PW-1:0]    w_rr_idx;
  logic [PW-1:0]    w_pick;
  logic             w_pick_found;
  logic [N_REQ-1:0] w_pick_onehot;
  logic [PW-1:0]    w_ptr_after;
  logic [1:0]       w_coin_g;
  logic             w_req_g;
  logic             w_ack_pending;
  logic             w_coin_valid;
  logic             w_coin_bad;
  logic [TW-1:0]    w_timer_inc;

  // Owner's coin and request; a coin still under acknowledge is stale for one cycle
  assign w_coin_g      = i_coin[{r_gidx, 1'b0} +: 2];
  assign w_req_g       = i_req[r_gidx];
  assign w_ack_pending = |r_coin_ack;
  assign w_coin_valid  = !w_ack_pending && ((w_coin_g == COIN_LOW) || (w_coin_g == COIN_HIGH));
  assign w_coin_bad    = !w_ack_pending && (w_coin_g == COIN_INVALID);
  assign w_timer_inc   = r_timer + 1'b1;
  assign w_ptr_after   = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
  assign w_pick_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;

  // Round-robin search: first requester at or after the pointer, wrapping around
  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    w_rr_sum     = '0;
    w_rr_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_rr_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_rr_sum >= (PW+1)'(N_REQ)) begin
        w_rr_sum = w_rr_sum - (PW+1)'(N_REQ);
      end
      w_rr_idx = w_rr_sum[PW-1:0];
      if (!w_pick_found && i_req[w_rr_idx]) begin
        w_pick       = w_rr_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  // Transaction FSM: next state and next registered outputs
  always_comb begin
    w_state_n       = r_state;
    w_ptr_n         = r_ptr;
    w_gidx_n        = r_gidx;
    w_grant_n       = r_grant;
    w_timer_n       = r_timer;
    w_win_n         = r_win;
    w_rcnt_n        = r_rcnt;
    w_coin_ack_n    = '0;
    w_done_n        = '0;
    w_done_change_n = COIN_NONE;
    w_abort_n       = '0;
    w_vm_in_n       = COIN_NONE;
    w_vm_rst_n      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_gidx_n  = w_pick;
          w_grant_n = w_pick_onehot;
          w_timer_n = '0;
          w_state_n = S_FEED;
        end
      end

      S_FEED: begin
        if (w_coin_valid) begin
          // A valid coin beats both a dropped request and the timeout
          w_vm_in_n    = w_coin_g;
          w_coin_ack_n = r_grant;
          w_timer_n    = '0;
          w_win_n      = '0;
          w_state_n    = S_RESP;
        end else if (!w_req_g) begin
          w_abort_n  = r_grant;
          w_vm_rst_n = 1'b1;
          w_rcnt_n   = '0;
          w_state_n  = S_ABORT;
        end else if (w_coin_bad) begin
          // Rejected coin: swallow it without touching the core
          w_coin_ack_n = r_grant;
          w_timer_n    = '0;
        end else if (w_timer_inc == TW'(TIMEOUT)) begin
          w_abort_n  = r_grant;
          w_vm_rst_n = 1'b1;
          w_rcnt_n   = '0;
          w_state_n  = S_ABORT;
        end else begin
          w_timer_n = w_timer_inc;
        end
      end

      S_RESP: begin
        if (i_vm_out) begin
          w_done_n        = r_grant;
          w_done_change_n = i_vm_change;
          w_grant_n       = '0;
          w_ptr_n         = w_ptr_after;
          w_state_n       = S_DONE;
        end else if (r_win == WW'(RESP_WIN - 1)) begin
          w_timer_n = '0;
          w_state_n = S_FEED;
        end else begin
          w_win_n = r_win + 1'b1;
        end
      end

      S_DONE: begin
        // One quiet cycle before the next grant can be issued
        w_state_n = S_IDLE;
      end

      S_ABORT: begin
        if (r_rcnt == CW'(RST_CYC - 1)) begin
          w_grant_n = '0;
          w_ptr_n   = w_ptr_after;
          w_state_n = S_IDLE;
        end else begin
          w_rcnt_n   = r_rcnt + 1'b1;
          w_vm_rst_n = 1'b1;
        end
      end

      default: begin
        w_grant_n = '0;
        w_state_n = S_IDLE;
      end
    endcase

    w_busy_n = |w_grant_n;
  end

  // State and output registers; reset holds the core in reset
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gidx        <= '0;
      r_grant       <= '0;
      r_timer       <= '0;
      r_win         <= '0;
      r_rcnt        <= '0;
      r_coin_ack    <= '0;
      r_done        <= '0;
      r_done_change <= COIN_NONE;
      r_abort       <= '0;
      r_busy        <= 1'b0;
      r_vm_in       <= COIN_NONE;
      r_vm_rst      <= 1'b1;
    end else begin
      r_state       <= w_state_n;
      r_ptr         <= w_ptr_n;
      r_gidx        <= w_gidx_n;
      r_grant       <= w_grant_n;
      r_timer       <= w_timer_n;
      r_win         <= w_win_n;
      r_rcnt        <= w_rcnt_n;
      r_coin_ack    <= w_coin_ack_n;
      r_done        <= w_done_n;
      r_done_change <= w_done_change_n;
      r_abort       <= w_abort_n;
      r_busy        <= w_busy_n;
      r_vm_in       <= w_vm_in_n;
      r_vm_rst      <= w_vm_rst_n;
    end
  end

  assign o_coin_ack    = r_coin_ack;
  assign o_grant       = r_grant;
  assign o_done        = r_done;
  assign o_done_change = r_done_change;
  assign o_abort       = r_abort;
  assign o_busy        = r_busy;
  assign o_vm_in       = r_vm_in;
  assign o_vm_rst      = r_vm_rst;

endmodule
